pattern_scan_arb: RTL and testbench

PATTERN_SCAN_ARB -- requirements
Module: pattern_scan_arb

---
 rtl/pattern_scan_arb.sv | 75 +++++++
 tb/tb_pattern_scan_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_arb.sv
// pattern_scan_arb: round-robin arbiter for two job requesters; streams the winner's word MSB first
// into an external 11010 Moore detector and reports how many matches it saw.
module pattern_scan_arb #(
   parameter int W  = 8,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   input  logic          req1_valid,
   input  logic [W-1:0]  req0_data,
   input  logic [W-1:0]  req1_data,
   output logic          req0_ready,
   output logic          req1_ready,
   output logic          det_rst,
   output logic          det_stream,
   input  logic          det_found,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          res_id,
   output logic [CW-1:0] res_count,
   output logic          busy
);
   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, RESULT} state_t;
   state_t        state, nxt;
   logic [W-1:0]  sreg;
   logic [CW-1:0] bcnt, count;
   logic          id, last, gnt1, any_valid;
   assign any_valid = req0_valid || req1_valid;
   // last holds the most recent grant; requester 1 wins a tie only when 0 went last
   assign gnt1 = req1_valid && (!req0_valid || !last);
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         bcnt  <= '0;
         count <= '0;
         id    <= 1'b0;
         last  <= 1'b1;
      end else begin
         state <= nxt;
         if (state == IDLE && any_valid) begin
            sreg  <= gnt1 ? req1_data : req0_data;
            id    <= gnt1;
            last  <= gnt1;
            count <= '0;
         end
         if (state == CLEAR) bcnt <= '0;
         if (state == SHIFT) begin
            sreg <= sreg << 1;
            bcnt <= bcnt + CW'(1);
         end
         if ((state == SHIFT || state == DRAIN) && det_found) count <= count + CW'(1);
      end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = any_valid ? CLEAR : IDLE;
         CLEAR:   nxt = SHIFT;
         SHIFT:   nxt = (bcnt == CW'(W - 1)) ? DRAIN : SHIFT;
         DRAIN:   nxt = RESULT;
         RESULT:  nxt = res_ready ? IDLE : RESULT;
         default: nxt = IDLE;
      endcase
   end
   // rst gates every output so the detector and requesters see a quiet block during reset
   assign req0_ready = !rst && state == IDLE && req0_valid && !gnt1;
   assign req1_ready = !rst && state == IDLE && gnt1;
   assign det_rst    = rst || state == CLEAR;
   assign det_stream = !rst && state == SHIFT && sreg[W-1];
   assign res_valid  = !rst && state == RESULT;
   assign res_id     = id;
   assign res_count  = count;
   assign busy       = !rst && state != IDLE;
endmodule

// File: tb/tb_pattern_scan_arb.sv
// tb_pattern_scan_arb: randomized and directed jobs against a behavioural model of arbitration,
// stream timing and 11010 match counting; the bench also plays the external detector.
module tb_pattern_scan_arb;
   localparam int W  = 8;
   localparam int CW = 4;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [W-1:0]  req0_data = '0, req1_data = '0;
   logic          req0_ready, req1_ready, det_rst, det_stream, det_found;
   logic          res_valid, res_ready = 1'b0, res_id, busy;
   logic [CW-1:0] res_count;
   logic [4:0]    hist = '0;
   int            n_chk = 0, n_fail = 0;
   bit            last_g = 1'b1;

   always #5 clk = ~clk;

   pattern_scan_arb #(.W(W), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_data(req0_data), .req1_data(req1_data),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .det_rst(det_rst), .det_stream(det_stream), .det_found(det_found),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_id(res_id), .res_count(res_count), .busy(busy)
   );

   // external Moore detector: flag reflects the last five bits presented before this cycle
   always_ff @(posedge clk) hist <= det_rst ? 5'd0 : {hist[3:0], det_stream};
   assign det_found = (hist == 5'b11010);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic int n_pat(input logic [W-1:0] d);
      int n = 0;
      for (int i = W - 1; i >= 4; i--) if (d[i -: 5] == 5'b11010) n++;
      return n;
   endfunction

   task automatic do_job(input bit v0, input bit v1, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input int hold, input bit scramble);
      bit           w;
      logic [W-1:0] dat;
      int           exp_n;
      w = (v0 && v1) ? !last_g : v1;
      req0_valid = v0;
      req1_valid = v1;
      req0_data  = d0;
      req1_data  = d1;
      #1;
      chk("ready0_grant", 32'(req0_ready), 32'(!w));
      chk("ready1_grant", 32'(req1_ready), 32'(w));
      dat    = w ? d1 : d0;
      exp_n  = n_pat(dat);
      last_g = w;
      step();
      if (scramble) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         req0_data  = W'($urandom);
         req1_data  = W'($urandom);
      end
      for (int i = 1; i <= W + 2; i++) begin
         #1;
         chk("det_rst", 32'(det_rst), 32'(i == 1));
         chk("det_stream", 32'(det_stream), (i >= 2 && i <= W + 1) ? 32'(dat[W + 1 - i]) : 32'd0);
         chk("busy_job", 32'(busy), 32'd1);
         chk("res_valid_early", 32'(res_valid), 32'd0);
         chk("readys_job", 32'({req0_ready, req1_ready}), 32'd0);
         step();
      end
      for (int k = 0; k <= hold; k++) begin
         res_ready = (k == hold);
         #1;
         chk("res_valid", 32'(res_valid), 32'd1);
         chk("res_id", 32'(res_id), 32'(w));
         chk("res_count", 32'(res_count), 32'(exp_n));
         chk("readys_result", 32'({req0_ready, req1_ready}), 32'd0);
         step();
         res_ready = 1'b0;
      end
      chk("busy_idle", 32'(busy), 32'd0);
      chk("res_valid_idle", 32'(res_valid), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_readys"}, 32'({req0_ready, req1_ready}), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_det_stream"}, 32'(det_stream), 32'd0);
      chk({tag, "_det_rst"}, 32'(det_rst), 32'd1);
   endtask

   task automatic abort_job(input logic [W-1:0] d0, input int cyc);
      req0_valid = 1'b1;
      req1_valid = 1'b0;
      req0_data  = d0;
      #1;
      chk("abort_grant", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      repeat (cyc - 1) step();
      rst = 1'b1;
      #1;
      chk_reset_outputs("abort_rst");
      step();
      rst    = 1'b0;
      last_g = 1'b1;
      #1;
      chk("busy_after_rst", 32'(busy), 32'd0);
      repeat (W + 4) begin
         chk("no_result_after_abort", 32'(res_valid), 32'd0);
         step();
      end
   endtask

   initial begin
      int v;
      step();
      step();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk_reset_outputs("reset");
      step();
      rst        = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk("idle_readys", 32'({req0_ready, req1_ready}), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_det_rst", 32'(det_rst), 32'd0);
      step();
      do_job(1, 0, 8'hD0, 8'h00, 0, 1);
      do_job(0, 1, 8'h00, 8'hDA, 0, 1);
      do_job(1, 0, 8'h00, 8'h00, 0, 1);
      do_job(1, 0, 8'hFF, 8'h00, 0, 1);
      rst = 1'b1;
      step();
      rst    = 1'b0;
      last_g = 1'b1;
      repeat (4) do_job(1, 1, 8'hD0, 8'hDA, 0, 0);
      do_job(1, 0, W'($urandom), 8'h00, 5, 1);
      abort_job(8'hD0, 5);
      do_job(1, 0, 8'hD0, 8'h00, 0, 1);
      abort_job(8'hDA, W + 3);
      do_job(1, 1, 8'h1A, 8'hDA, 1, 1);
      for (int j = 0; j < 24; j++) begin
         v = $urandom_range(1, 3);
         do_job(v[0], v[1], W'($urandom), W'($urandom), $urandom_range(0, 3), 1'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
